// File: rtl/quadrature_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : quadrature_decoder                                           |
// | Description : A/B/index quadrature decoder with position counter, sticky   |
// |               illegal-transition flag and index capture. Define            |
// |               QDEC_FILTER_EN to add a FILT_LEN-sample input stability      |
// |               filter on the synchronized A and B channels.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module quadrature_decoder #(
    parameter int WIDTH    = 32,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             idx_in,
    input  logic             clear,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic [WIDTH-1:0] idx_count
);

    logic       r_a_s1, r_a_s2;
    logic       r_b_s1, r_b_s2;
    logic       r_idx_s1, r_idx_s2, r_idx_d;
    logic [1:0] w_ab;
    logic [1:0] r_ab_prev;
    logic       r_primed;
    logic [1:0] w_pos_cur;
    logic [1:0] w_pos_prev;
    logic [1:0] w_delta;
    logic       w_up;
    logic       w_dn;
    logic       w_ill;
    logic       w_idx_rise;

    if (FILT_LEN < 1) begin : g_filt_len_invalid
        $error("quadrature_decoder: FILT_LEN must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_s1   <= 1'b0;
            r_a_s2   <= 1'b0;
            r_b_s1   <= 1'b0;
            r_b_s2   <= 1'b0;
            r_idx_s1 <= 1'b0;
            r_idx_s2 <= 1'b0;
        end else begin
            r_a_s1   <= a_in;
            r_a_s2   <= r_a_s1;
            r_b_s1   <= b_in;
            r_b_s2   <= r_b_s1;
            r_idx_s1 <= idx_in;
            r_idx_s2 <= r_idx_s1;
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int c_FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0] w_sync;
    assign w_sync = {r_a_s2, r_b_s2};

    // A channel level is accepted only after FILT_LEN consecutive differing samples.
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic [c_FCW-1:0] r_cnt;
        logic             r_lvl;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (w_sync[gi] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt >= c_FCW'(FILT_LEN - 1)) begin
                r_lvl <= w_sync[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_ab[gi] = r_lvl;
    end
`else
    assign w_ab = {r_a_s2, r_b_s2};
`endif

    // Map (A,B) onto a 2-bit phase so the up sequence 00,10,11,01 counts 0..3.
    assign w_pos_cur  = {w_ab[0], w_ab[1] ^ w_ab[0]};
    assign w_pos_prev = {r_ab_prev[0], r_ab_prev[1] ^ r_ab_prev[0]};
    assign w_delta    = w_pos_cur - w_pos_prev;
    assign w_up       = r_primed && (w_delta == 2'd1);
    assign w_dn       = r_primed && (w_delta == 2'd3);
    assign w_ill      = r_primed && (w_delta == 2'd2);
    assign w_idx_rise = r_idx_s2 && !r_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            idx_count <= '0;
            dir       <= 1'b1;
            step      <= 1'b0;
            err       <= 1'b0;
            r_ab_prev <= 2'b00;
            r_primed  <= 1'b0;
            r_idx_d   <= 1'b0;
        end else begin
            r_ab_prev <= w_ab;
            r_primed  <= 1'b1;
            r_idx_d   <= r_idx_s2;
            step      <= w_up || w_dn;

            if (w_idx_rise) begin
                idx_count <= count;
            end

            if (w_up) begin
                count <= count + WIDTH'(1);
                dir   <= 1'b1;
            end else if (w_dn) begin
                count <= count - WIDTH'(1);
                dir   <= 1'b0;
            end

            // Clear wins over the count update only; dir and step still follow the edge.
            if (clear) begin
                count <= '0;
            end

            if (w_ill) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_quadrature_decoder                                        |
// | Description : Directed self-checking bench for quadrature_decoder.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_quadrature_decoder;

    localparam int WIDTH = 32;
`ifdef QDEC_FILTER_EN
    localparam int c_LAT = 3 + 3;
`else
    localparam int c_LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_in = 1'b0;
    logic             b_in = 1'b0;
    logic             idx_in = 1'b0;
    logic             clear = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;
    logic [WIDTH-1:0] idx_count;

    int n_tests  = 0;
    int n_fail   = 0;
    int step_cnt = 0;
    int base;

    quadrature_decoder #(.WIDTH(WIDTH), .FILT_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .idx_in    (idx_in),
        .clear     (clear),
        .err_clr   (err_clr),
        .count     (count),
        .dir       (dir),
        .step      (step),
        .err       (err),
        .idx_count (idx_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (step === 1'b1) step_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ab(input logic a, input logic b);
        @(negedge clk);
        a_in = a;
        b_in = b;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] up_seq [4];
        up_seq[0] = 2'b10;
        up_seq[1] = 2'b11;
        up_seq[2] = 2'b01;
        up_seq[3] = 2'b00;

        // Reset state
        wait_clk(3);
        check("rst_count", count, 32'd0);
        check("rst_idx_count", idx_count, 32'd0);
        check("rst_dir", {31'd0, dir}, 32'd1);
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_clk(4);

        // Full up cycle, each state held 8 clocks
        base = step_cnt;
        for (int i = 0; i < 4; i++) begin
            set_ab(up_seq[i][1], up_seq[i][0]);
            wait_clk(8);
        end
        check("up4_count", count, 32'd4);
        check("up4_dir", {31'd0, dir}, 32'd1);
        check("up4_steps", step_cnt - base, 32'd4);
        check("up4_err", {31'd0, err}, 32'd0);

        // Pin-to-output latency
        set_ab(1'b1, 1'b0);
        wait_clk(c_LAT - 1);
        check("lat_early_step", {31'd0, step}, 32'd0);
        check("lat_early_count", count, 32'd4);
        wait_clk(1);
        check("lat_step", {31'd0, step}, 32'd1);
        check("lat_count", count, 32'd5);
        wait_clk(1);
        check("lat_step_end", {31'd0, step}, 32'd0);

        // Index capture, 4-clock pulse at count=5
        @(negedge clk);
        idx_in = 1'b1;
        repeat (4) @(negedge clk);
        idx_in = 1'b0;
        wait_clk(4);
        check("idx_capture", idx_count, 32'd5);
        check("idx_count_kept", count, 32'd5);

        // Down steps back to zero: 10->00->01->11->10->00
        set_ab(1'b0, 1'b0);
        wait_clk(c_LAT + 2);
        check("dn_count4", count, 32'd4);
        check("dn_dir", {31'd0, dir}, 32'd0);
        set_ab(1'b0, 1'b1); wait_clk(c_LAT + 2);
        set_ab(1'b1, 1'b1); wait_clk(c_LAT + 2);
        set_ab(1'b1, 1'b0); wait_clk(c_LAT + 2);
        set_ab(1'b0, 1'b0); wait_clk(c_LAT + 2);
        check("dn_count0", count, 32'd0);

        // Wrap below zero and back
        set_ab(1'b0, 1'b1);
        wait_clk(c_LAT + 2);
        check("wrap_dn_count", count, 32'hFFFF_FFFF);
        check("wrap_dn_dir", {31'd0, dir}, 32'd0);
        set_ab(1'b0, 1'b0);
        wait_clk(c_LAT + 2);
        check("wrap_up_count", count, 32'd0);
        check("wrap_up_dir", {31'd0, dir}, 32'd1);

        // Illegal 00->11 jump, then err_clr
        base = step_cnt;
        set_ab(1'b1, 1'b1);
        wait_clk(c_LAT + 2);
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_count", count, 32'd0);
        check("ill_dir", {31'd0, dir}, 32'd1);
        check("ill_nostep", step_cnt - base, 32'd0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("errclr", {31'd0, err}, 32'd0);

        // err_clr held while a second illegal jump 11->00 is decoded
        set_ab(1'b0, 1'b0);
        err_clr = 1'b1;
        wait_clk(c_LAT);
        @(negedge clk);
        err_clr = 1'b0;
        check("errclr_vs_ill", {31'd0, err}, 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("errclr2", {31'd0, err}, 32'd0);

        // Count up to 9 (ends at 10)
        for (int i = 0; i < 9; i++) begin
            set_ab(up_seq[i % 4][1], up_seq[i % 4][0]);
            wait_clk(c_LAT + 1);
        end
        check("up9_count", count, 32'd9);

        // Clear coincident with decoded up step 10->11
        set_ab(1'b1, 1'b1);
        repeat (c_LAT - 1) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clr_count", count, 32'd0);
        check("clr_dir", {31'd0, dir}, 32'd1);
        check("clr_step", {31'd0, step}, 32'd1);
        @(negedge clk);
        clear = 1'b0;

        // Index rise coincident with clear captures the pre-clear count
        set_ab(1'b0, 1'b1);
        wait_clk(c_LAT + 2);
        check("pre_idxclr_count", count, 32'd1);
        @(negedge clk);
        idx_in = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("idxclr_idx_count", idx_count, 32'd1);
        check("idxclr_count", count, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        idx_in = 1'b0;
        wait_clk(3);

`ifdef QDEC_FILTER_EN
        // Short glitch on A is rejected; a long level yields one step
        base = step_cnt;
        set_ab(1'b0, 1'b0);
        wait_clk(c_LAT + 2);
        base = step_cnt;
        @(negedge clk);
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        a_in = 1'b0;
        wait_clk(10);
        check("filt_glitch", step_cnt - base, 32'd0);
        set_ab(1'b1, 1'b0);
        wait_clk(5);
        check("filt_early", {31'd0, step}, 32'd0);
        wait_clk(1);
        check("filt_step", {31'd0, step}, 32'd1);
        wait_clk(4);
        check("filt_one", step_cnt - base, 32'd1);
`endif

        // Reset mid-transition and with pending state
        set_ab(~a_in, b_in);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        check("rst2_step", {31'd0, step}, 32'd0);
        check("rst2_count", count, 32'd0);
        check("rst2_idx_count", idx_count, 32'd0);
        check("rst2_dir", {31'd0, dir}, 32'd1);
        check("rst2_err", {31'd0, err}, 32'd0);
        wait_clk(3);
        check("rst2_step_hold", {31'd0, step}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter WIDTH, default 32: bit width of position counter and index capture register.
REQ-002 Parameter FILT_LEN, default 3: input stability length in clocks; used only when QDEC_FILTER_EN is defined.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_in  input  1  encoder channel A, asynchronous to clk.
REQ-006 b_in  input  1  encoder channel B, asynchronous to clk.
REQ-007 idx_in  input  1  encoder index pulse, asynchronous to clk.
REQ-008 clear  input  1  synchronous position clear, active-high.
REQ-009 err_clr  input  1  clears sticky error flag, active-high.
REQ-010 count  output  WIDTH  current position, two's-complement modulo 2^WIDTH.
REQ-011 dir  output  1  direction of last valid transition; 1 = up, 0 = down.
REQ-012 step  output  1  one-clock pulse per valid transition.
REQ-013 err  output  1  sticky illegal-transition flag.
REQ-014 idx_count  output  WIDTH  count value captured at last index rising edge.

Function
REQ-015 a_in, b_in and idx_in SHALL each pass through a 2-flop synchronizer before any use.
REQ-016 Decoder SHALL keep previous (A,B) state and compare it with the current synchronized (A,B) each clock.
REQ-017 Up sequence (A,B): 00->10->11->01->00; each such single-bit step SHALL increment count by 1, set dir=1, pulse step.
REQ-018 Down sequence: 00->01->11->10->00; each such step SHALL decrement count by 1, set dir=0, pulse step.
REQ-019 No change in (A,B) SHALL leave count, dir unchanged and step=0.
REQ-020 Both bits changing in one clock SHALL set err=1, leave count and dir unchanged, step=0.
REQ-021 count SHALL wrap: all-ones +1 -> 0; 0 -1 -> all-ones; no saturation, no flag.
REQ-022 Latency: pin edge to count/step/dir update SHALL be exactly 3 clocks (2 sync + 1 decode) with filter disabled.
REQ-023 clear=1 SHALL load count=0 next clock, overriding a simultaneous valid transition; dir and step still reflect that transition; previous-state register still updates.
REQ-024 Synchronized idx rising edge SHALL load idx_count with count value before that cycle's update.
REQ-025 idx rising edge coincident with clear SHALL capture the pre-clear count.
REQ-026 err_clr=1 SHALL clear err unless an illegal transition occurs in the same cycle, in which case err stays 1.
REQ-027 First clock after rst deasserts SHALL only load previous state from synchronized inputs (prime cycle): no count change, no step, no err.

Reset
REQ-028 rst SHALL set count=0, idx_count=0, dir=1, step=0, err=0, synchronizer flops=0, prime flag armed.
REQ-029 rst asserted mid-transition SHALL discard pending transitions; no step pulse in the cycle after rst.
REQ-030 rst SHALL take priority over clear, err_clr and all transitions.

Configuration
REQ-031 Macro QDEC_FILTER_EN defined: A and B after synchronization SHALL each be accepted only after FILT_LEN consecutive equal samples; shorter pulses ignored; latency becomes 3+FILT_LEN clocks; filter counters reset to 0 by rst, filtered outputs to 0.
REQ-032 QDEC_FILTER_EN undefined: no filter logic present, FILT_LEN ignored, latency per REQ-022.

Verification
REQ-033 After reset, drive A,B through 00,10,11,01,00 each held 8 clocks -> count=4, dir=1, 4 step pulses, err=0.
REQ-034 From count=0, one down step 00->01 -> count=all-ones (0xFFFFFFFF at WIDTH=32), dir=0.
REQ-035 Jump A,B 00->11 in one clock -> err=1, count unchanged; then err_clr pulse -> err=0.
REQ-036 count=5, idx_in pulse 4 clocks wide -> idx_count=5 after sync delay; count unaffected.
REQ-037 clear asserted in same cycle a valid up step is decoded, count=9 -> count=0, dir=1, step=1.
REQ-038 QDEC_FILTER_EN, FILT_LEN=3: 2-clock glitch on A -> no step; 10-clock level on A -> one step after 6 clocks.
